// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, reads one word at a time from instruction
// memory over req/ack and hands it to decode over valid/ready, honouring redirects.
module ifetch_unit #(
   parameter int                  PC_WIDTH    = 10,
   parameter int                  INSTR_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
   parameter int                  CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   imem_req,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic                   imem_ack,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [INSTR_WIDTH-1:0] instr_out,
   output logic [PC_WIDTH-1:0]    pc_next_out,
   input  logic                   redirect_valid,
   input  logic [PC_WIDTH-1:0]    redirect_target,
   output logic                   fetch_fault,
   output logic [CNT_WIDTH-1:0]   fetch_count
);

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_HOLD,
      ST_HALT
   } state_t;

   state_t                state_reg;
   logic [PC_WIDTH-1:0]   pc_reg;
   logic [PC_WIDTH-1:2]   req_addr_reg;
   logic                  squash_reg;

   logic [PC_WIDTH-1:0]   pc_inc;
   logic [PC_WIDTH-1:2]   addr_word;
   logic                  redirect_ok;
   logic                  redirect_bad;

   assign pc_inc       = pc_reg + PC_WIDTH'(4);
   assign redirect_bad = redirect_valid & (redirect_target[1:0] != 2'b00);
   assign redirect_ok  = redirect_valid & (redirect_target[1:0] == 2'b00);

   assign imem_req = (state_reg == ST_FETCH);

   // While a squashed read is still outstanding, pc already holds the redirect
   // target, so the bus must keep showing the address that was originally issued.
   assign addr_word = squash_reg ? req_addr_reg : pc_reg[PC_WIDTH-1:2];

   genvar gi;
   generate
      for (gi = 0; gi < PC_WIDTH; gi++) begin : g_addr
         if (gi < 2) begin : g_lo
            assign imem_addr[gi] = 1'b0;
         end else begin : g_hi
            assign imem_addr[gi] = addr_word[gi];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_FETCH;
         pc_reg       <= RESET_PC;
         req_addr_reg <= '0;
         squash_reg   <= 1'b0;
         instr_valid  <= 1'b0;
         instr_out    <= '0;
         pc_next_out  <= '0;
         fetch_fault  <= 1'b0;
         fetch_count  <= '0;
      end else begin
         case (state_reg)
            ST_FETCH: begin
               if (redirect_bad) begin
                  fetch_fault <= 1'b1;
                  instr_valid <= 1'b0;
                  squash_reg  <= 1'b0;
                  state_reg   <= ST_HALT;
               end else if (imem_ack) begin
                  if (squash_reg | redirect_ok) begin
                     // Wrong-path data: drop it and restart at the pending target.
                     if (redirect_ok) begin
                        pc_reg <= redirect_target;
                     end
                     squash_reg <= 1'b0;
                  end else begin
                     instr_out   <= imem_rdata;
                     pc_next_out <= pc_inc;
                     pc_reg      <= pc_inc;
                     instr_valid <= 1'b1;
                     state_reg   <= ST_HOLD;
                  end
               end else if (redirect_ok) begin
                  if (!squash_reg) begin
                     req_addr_reg <= pc_reg[PC_WIDTH-1:2];
                  end
                  pc_reg     <= redirect_target;
                  squash_reg <= 1'b1;
               end
            end

            ST_HOLD: begin
               if (redirect_bad) begin
                  fetch_fault <= 1'b1;
                  instr_valid <= 1'b0;
                  state_reg   <= ST_HALT;
               end else if (redirect_ok) begin
                  // Redirect beats a same-cycle handoff: the held word is wrong-path.
                  instr_valid <= 1'b0;
                  pc_reg      <= redirect_target;
                  state_reg   <= ST_FETCH;
               end else if (instr_ready) begin
                  instr_valid <= 1'b0;
                  fetch_count <= fetch_count + CNT_WIDTH'(1);
                  state_reg   <= ST_FETCH;
               end
            end

            default: begin
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus randomized traffic checked every
// cycle against a memory-side behavioural model of the fetch stage.
module tb_ifetch_unit;

   localparam int PCW = 10;
   localparam int IW  = 32;
   localparam int CW  = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic           imem_req;
   logic [PCW-1:0] imem_addr;
   logic           imem_ack;
   logic [IW-1:0]  imem_rdata;
   logic           instr_valid;
   logic           instr_ready;
   logic [IW-1:0]  instr_out;
   logic [PCW-1:0] pc_next_out;
   logic           redirect_valid;
   logic [PCW-1:0] redirect_target;
   logic           fetch_fault;
   logic [CW-1:0]  fetch_count;

   ifetch_unit #(
      .PC_WIDTH   (PCW),
      .INSTR_WIDTH(IW),
      .RESET_PC   (10'h000),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_out      (instr_out),
      .pc_next_out    (pc_next_out),
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target),
      .fetch_fault    (fetch_fault),
      .fetch_count    (fetch_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // stimulus controls used by the directed scenarios
   logic           cfg_rand  = 1'b0;
   logic           cfg_reset = 1'b0;
   logic           cfg_ready = 1'b0;
   logic           cfg_redir = 1'b0;
   logic [PCW-1:0] cfg_tgt   = '0;
   int             cfg_lat   = 0;

   // instruction memory: one read at a time, fixed or random latency
   logic           mem_busy = 1'b0;
   logic [PCW-1:0] mem_addr = '0;
   int             mem_wait = 0;

   // behavioural model of what decode and memory should observe
   typedef enum logic [1:0] {M_FETCH, M_HOLD, M_HALT} mmode_t;
   mmode_t         m_mode  = M_FETCH;
   logic [PCW-1:0] m_pc    = '0;
   logic           m_drop  = 1'b0;
   logic           m_valid = 1'b0;
   logic [IW-1:0]  m_instr = '0;
   logic [PCW-1:0] m_pcn   = '0;
   logic           m_fault = 1'b0;
   logic [CW-1:0]  m_count = '0;

   function automatic logic [IW-1:0] word_at(input logic [PCW-1:0] a);
      return 32'h1357_9BDF ^ {a, a, a, 2'b01};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One cycle: compare outputs at negedge, choose inputs, advance memory and model.
   task automatic step();
      logic           rst;
      logic           ack;
      logic           rdy;
      logic           rv;
      logic [PCW-1:0] tgt;
      int             lat;
      @(negedge clk);
      chk("req",     imem_req,    m_mode == M_FETCH);
      chk("valid",   instr_valid, m_valid);
      chk("fault",   fetch_fault, m_fault);
      chk("count",   fetch_count, m_count);
      chk("instr",   instr_out,   m_instr);
      chk("pc_next", pc_next_out, m_pcn);

      if (cfg_rand) begin
         rst = ($urandom_range(0, 199) == 0);
         rdy = ($urandom_range(0, 2) != 0);
         rv  = ($urandom_range(0, 7) == 0);
         tgt = PCW'($urandom) & ~PCW'(3);
         if ($urandom_range(0, 15) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
         lat = $urandom_range(0, 3);
      end else begin
         rst = cfg_reset;
         rdy = cfg_ready;
         rv  = cfg_redir;
         tgt = cfg_tgt;
         lat = cfg_lat;
      end

      ack = 1'b0;
      if (!imem_req) begin
         mem_busy = 1'b0;
      end else if (!mem_busy) begin
         chk("req_addr", imem_addr, m_pc);
         mem_busy = 1'b1;
         mem_addr = m_pc;
         mem_wait = lat;
      end else begin
         chk("addr_hold", imem_addr, mem_addr);
      end
      if (mem_busy) begin
         if (mem_wait == 0) begin
            ack      = 1'b1;
            mem_busy = 1'b0;
         end else begin
            mem_wait--;
         end
      end
      if (rst) begin
         ack      = 1'b0;
         mem_busy = 1'b0;
      end

      reset           = rst;
      imem_ack        = ack;
      imem_rdata      = ack ? word_at(mem_addr) : $urandom;
      instr_ready     = rdy;
      redirect_valid  = rv;
      redirect_target = tgt;

      if (rst) begin
         m_mode = M_FETCH; m_pc = '0; m_drop = 1'b0; m_valid = 1'b0;
         m_instr = '0; m_pcn = '0; m_fault = 1'b0; m_count = '0;
      end else if (m_mode != M_HALT && rv && tgt[1:0] != 2'b00) begin
         m_mode = M_HALT; m_fault = 1'b1; m_valid = 1'b0; m_drop = 1'b0;
      end else if (m_mode == M_FETCH) begin
         if (ack) begin
            if (m_drop || rv) begin
               if (rv) m_pc = tgt;
               m_drop = 1'b0;
            end else begin
               m_instr = word_at(mem_addr);
               m_pcn   = mem_addr + 10'd4;
               m_pc    = m_pcn;
               m_valid = 1'b1;
               m_mode  = M_HOLD;
            end
         end else if (rv) begin
            m_pc   = tgt;
            m_drop = 1'b1;
         end
      end else if (m_mode == M_HOLD) begin
         if (rv) begin
            m_valid = 1'b0; m_pc = tgt; m_mode = M_FETCH;
         end else if (rdy) begin
            m_valid = 1'b0; m_count = m_count + 16'd1; m_mode = M_FETCH;
         end
      end
   endtask

   task automatic do_reset();
      cfg_reset = 1'b1;
      step();
      cfg_reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1);
   end

   initial begin
      reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
      redirect_valid = 1'b0; redirect_target = '0;
      @(posedge clk);

      // 1: back-to-back fetches with immediate ack and ready
      cfg_lat = 0; cfg_ready = 1'b1; cfg_redir = 1'b0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         chk("s1_req", imem_req, 1'b1);
         chk("s1_addr", imem_addr, 10'(4 * i));
         if (i == 0) chk("s1_count0", fetch_count, 16'd0);
         step();
         chk("s1_pcn", pc_next_out, 10'(4 * i + 4));
         if (i == 0) chk("s1_instr0", instr_out, 32'h1357_9BDE);
      end
      step();
      chk("s1_count3", fetch_count, 16'd3);

      // 2: slow memory, decode stalls in HOLD
      cfg_lat = 3; cfg_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step();
         chk("s2_req", imem_req, 1'b1);
         chk("s2_addr", imem_addr, 10'h000);
         chk("s2_novalid", instr_valid, 1'b0);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         chk("s2_valid", instr_valid, 1'b1);
         chk("s2_noreq", imem_req, 1'b0);
         chk("s2_instr", instr_out, 32'h1357_9BDE);
         chk("s2_pcn", pc_next_out, 10'h004);
         chk("s2_count", fetch_count, 16'd0);
      end
      cfg_ready = 1'b1; step(); cfg_ready = 1'b0;
      step();
      chk("s2_count1", fetch_count, 16'd1);
      chk("s2_addr4", imem_addr, 10'h004);

      // 3: redirect while the read of 0x08 is outstanding
      cfg_lat = 0; cfg_ready = 1'b1;
      do_reset();
      step(); step(); step(); step();
      cfg_lat = 3;
      step();
      chk("s3_addr8", imem_addr, 10'h008);
      cfg_redir = 1'b1; cfg_tgt = 10'h040;
      step();
      cfg_redir = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("s3_addr_held", imem_addr, 10'h008);
         chk("s3_novalid", instr_valid, 1'b0);
         if (i == 1) cfg_lat = 0;
         step();
      end
      chk("s3_addr40", imem_addr, 10'h040);
      chk("s3_novalid2", instr_valid, 1'b0);
      step();
      chk("s3_pcn44", pc_next_out, 10'h044);
      chk("s3_count2", fetch_count, 16'd2);

      // 4: redirect and ready together in HOLD
      cfg_lat = 0; cfg_ready = 1'b0;
      do_reset();
      step();
      cfg_ready = 1'b1; cfg_redir = 1'b1; cfg_tgt = 10'h020;
      step();
      chk("s4_valid", instr_valid, 1'b1);
      cfg_ready = 1'b0; cfg_redir = 1'b0;
      step();
      chk("s4_addr20", imem_addr, 10'h020);
      chk("s4_count0", fetch_count, 16'd0);
      chk("s4_novalid", instr_valid, 1'b0);
      step();
      chk("s4_pcn24", pc_next_out, 10'h024);

      // 5: misaligned redirect halts until reset
      do_reset();
      step();
      cfg_redir = 1'b1; cfg_tgt = 10'h022;
      step();
      cfg_tgt = 10'h040; cfg_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("s5_fault", fetch_fault, 1'b1);
         chk("s5_noreq", imem_req, 1'b0);
         chk("s5_novalid", instr_valid, 1'b0);
      end
      cfg_redir = 1'b0; cfg_ready = 1'b0;
      do_reset();
      step();
      chk("s5_fault_clr", fetch_fault, 1'b0);
      chk("s5_req", imem_req, 1'b1);
      chk("s5_addr0", imem_addr, 10'h000);

      // 6: PC wrap at the top of the address space
      cfg_lat = 0; cfg_ready = 1'b0;
      do_reset();
      step();
      cfg_redir = 1'b1; cfg_tgt = 10'h3FC;
      step();
      cfg_redir = 1'b0;
      step();
      chk("s6_addr3fc", imem_addr, 10'h3FC);
      step();
      chk("s6_pcn0", pc_next_out, 10'h000);
      chk("s6_nofault", fetch_fault, 1'b0);
      cfg_ready = 1'b1; step(); cfg_ready = 1'b0;
      step();
      chk("s6_addr0", imem_addr, 10'h000);

      // randomized traffic
      for (int seg = 0; seg < 20; seg++) begin
         cfg_rand = 1'b0;
         do_reset();
         cfg_rand = 1'b1;
         for (int c = 0; c < 300; c++) step();
      end
      cfg_rand = 1'b0;
      do_reset();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
